// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared types, constants and round-robin pick helper for the
//               nibble-serial shared adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Width of the shared adder slice
    localparam int NIBBLE  = 4;
    // Upper bound on the requester count the pick helper handles
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // First valid requester at or after ptr, wrapping modulo nreq.
    // Returns ptr when nothing is valid; callers gate on |valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic found;
        int   j;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % nreq;
            if (k < nreq && !found && valid[j]) begin
                rr_pick = 3'(j);
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder_slice
// Description : 4-bit ripple-carry adder slice; the single shared arithmetic
//               resource of the controller. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    // One full adder per bit, carry rippling upward
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_ctrl
// Description : Round-robin arbiter and controller that time-shares one 4-bit
//               adder slice among NREQ requesters, computing WIDTH-bit sums
//               nibble-serially (LSB nibble first) with a registered carry.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_ctrl
    import adder_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    localparam int NNIB = WIDTH / NIBBLE;
    localparam int CNTW = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_t            r_state;
    logic [IDW-1:0]    r_rr_ptr;
    logic [CNTW-1:0]   r_nib;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic [IDW-1:0]    r_id;
    logic              r_valid;

    logic [MAX_REQ-1:0] w_valid8;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_next_ptr;
    logic               w_accept;
    logic [3:0]         w_nsum;
    logic               w_ncout;
    logic               w_last;

    // Widen the request vector to the fixed width the pick helper expects
    always_comb begin
        w_valid8             = '0;
        w_valid8[NREQ-1:0]   = req_valid;
    end

    assign w_grant    = IDW'(rr_pick(w_valid8, 3'(r_rr_ptr), NREQ));
    assign w_next_ptr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
    assign w_last     = (r_nib == CNTW'(NNIB - 1));

    // Grant is offered only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (!rst && r_state == IDLE && |req_valid) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & req_ready);

    nibble_adder_slice u_slice (
        .a    (r_a[r_nib*NIBBLE +: NIBBLE]),
        .b    (r_b[r_nib*NIBBLE +: NIBBLE]),
        .cin  (r_carry),
        .sum  (w_nsum),
        .cout (w_ncout)
    );

    // Controller: accept, run N nibble cycles, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_nib    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_id     <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= req_a[w_grant*WIDTH +: WIDTH];
                        r_b      <= req_b[w_grant*WIDTH +: WIDTH];
                        r_id     <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                        r_carry  <= 1'b0;
                        r_nib    <= '0;
                        r_state  <= ADD;
                    end
                end
                ADD: begin
                    r_sum[r_nib*NIBBLE +: NIBBLE] <= w_nsum;
                    r_carry <= w_ncout;
                    r_nib   <= r_nib + CNTW'(1);
                    // No early exit: every operation takes exactly N nibble cycles
                    if (w_last) begin
                        r_nib   <= '0;
                        r_cout  <= w_ncout;
                        r_valid <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

endmodule
`default_nettype wire
